// File: rtl/nonce_search_ctrl.sv
// -----------------------------------------------------------------------------
// nonce_search_ctrl
//
// Purpose:
//   Sequencer for the micro-hash core. It walks an inclusive nonce range for a
//   12-byte block header. For each nonce it launches one hash, waits for the
//   core to finish, and checks the top two result bytes against the target.
//   It stops on the first passing nonce, on range exhaustion, or when the core
//   fails to answer within TIMEOUT_CYC cycles.
//
// Parameters:
//   TIMEOUT_CYC  maximum number of WAIT cycles before giving up (ERROR)
//   CNT_W        width of the saturating attempt counter
//
// Ports:
//   clk          clock, all state on posedge
//   reset        asynchronous active-high reset
//   start        one-cycle request, accepted in IDLE or a terminal state
//   abort        return to IDLE on the next cycle from any state
//   header_in    block header (byte 11 in [95:88])
//   nonce_first  first nonce of the range
//   nonce_last   last nonce of the range (inclusive, may wrap)
//   target_in    difficulty target
//   hash_start   one-cycle launch pulse to the hash core
//   hash_header  header presented to the core
//   hash_nonce   nonce presented to the core
//   hash_done    core completion strobe
//   hash_out     core result, valid with hash_done
//   busy         high in LAUNCH/WAIT/CHECK
//   found        high in FOUND
//   exhausted    high in EXHAUST
//   error        high in ERROR
//   nonce_found  nonce that passed
//   hash_found   hash that passed
//   attempts     hashes completed since the last accepted start
// -----------------------------------------------------------------------------
module nonce_search_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [95:0]      header_in,
  input  logic [31:0]      nonce_first,
  input  logic [31:0]      nonce_last,
  input  logic [7:0]       target_in,
  output logic             hash_start,
  output logic [95:0]      hash_header,
  output logic [31:0]      hash_nonce,
  input  logic             hash_done,
  input  logic [23:0]      hash_out,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic             error,
  output logic [31:0]      nonce_found,
  output logic [23:0]      hash_found,
  output logic [CNT_W-1:0] attempts
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUST,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [95:0]        header_q, header_d;
  logic [7:0]         target_q, target_d;
  logic [31:0]        last_q, last_d;
  logic [31:0]        nonce_q, nonce_d;
  logic [31:0]        nonce_found_q, nonce_found_d;
  logic [23:0]        hash_q, hash_d;
  logic [23:0]        hash_found_q, hash_found_d;
  logic [CNT_W-1:0]   attempts_q, attempts_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               pass;

  // Both of the upper result bytes must be strictly below the target, so a
  // target of zero can never pass.
  assign pass = (hash_q[23:16] < target_q) && (hash_q[15:8] < target_q);

  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    target_d      = target_q;
    last_d        = last_q;
    nonce_d       = nonce_q;
    nonce_found_d = nonce_found_q;
    hash_d        = hash_q;
    hash_found_d  = hash_found_q;
    attempts_d    = attempts_q;
    tmo_d         = tmo_q;

    if (abort) begin
      // Abort overrides everything, including a simultaneous start.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUST, S_ERROR: begin
          if (start) begin
            header_d   = header_in;
            target_d   = target_in;
            last_d     = nonce_last;
            nonce_d    = nonce_first;
            attempts_d = '0;
            state_d    = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (hash_done) begin
            hash_d = hash_out;
            if (attempts_q != '1) begin
              attempts_d = attempts_q + CNT_W'(1);
            end
            state_d = S_CHECK;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            // TIMEOUT_CYC WAIT cycles have elapsed with no answer.
            state_d = S_ERROR;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_CHECK: begin
          // A pass on the last nonce reports FOUND, not EXHAUST.
          if (pass) begin
            nonce_found_d = nonce_q;
            hash_found_d  = hash_q;
            state_d       = S_FOUND;
          end else if (nonce_q == last_q) begin
            state_d = S_EXHAUST;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = S_LAUNCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      header_q      <= '0;
      target_q      <= '0;
      last_q        <= '0;
      nonce_q       <= '0;
      nonce_found_q <= '0;
      hash_q        <= '0;
      hash_found_q  <= '0;
      attempts_q    <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      target_q      <= target_d;
      last_q        <= last_d;
      nonce_q       <= nonce_d;
      nonce_found_q <= nonce_found_d;
      hash_q        <= hash_d;
      hash_found_q  <= hash_found_d;
      attempts_q    <= attempts_d;
      tmo_q         <= tmo_d;
    end
  end

  assign hash_start  = (state_q == S_LAUNCH);
  assign busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign found       = (state_q == S_FOUND);
  assign exhausted   = (state_q == S_EXHAUST);
  assign error       = (state_q == S_ERROR);
  assign hash_header = header_q;
  assign hash_nonce  = nonce_q;
  assign nonce_found = nonce_found_q;
  assign hash_found  = hash_found_q;
  assign attempts    = attempts_q;

endmodule
